// File: rtl/snow64_lar_mem_bridge_pkg.sv
// Shared types and constants for the LAR file <-> memory bus bridge.
// Declarations only; no logic and no latency of their own.
// The bus structs group the beat-level request and response signals.
`ifndef SNOW64_LAR_MEM_BRIDGE_PKG_SV
`define SNOW64_LAR_MEM_BRIDGE_PKG_SV

// MSB position of the beat counter; a line is 4 beats, so the counter is [1:0].
`define MSB_POS__SNOW64_LAR_MEM_BRIDGE_BEAT 1

package PkgSnow64Cpu;
  localparam int WIDTH__CPU_ADDR = 64;
  typedef logic [WIDTH__CPU_ADDR-1:0] CpuAddr;
endpackage

package PkgSnow64LarFile;
  localparam int WIDTH__LAR_DATA      = 256;
  localparam int WIDTH__LAR_BASE_ADDR = 59;
  localparam int WIDTH__MEM_BUS_DATA  = 64;
  localparam int BEATS                = WIDTH__LAR_DATA / WIDTH__MEM_BUS_DATA;

  typedef logic [WIDTH__LAR_DATA-1:0]                 LarData;
  typedef logic [WIDTH__LAR_BASE_ADDR-1:0]            LarBaseAddr;
  typedef logic [WIDTH__MEM_BUS_DATA-1:0]             MemBusData;
  typedef logic [`MSB_POS__SNOW64_LAR_MEM_BRIDGE_BEAT:0] BeatIdx;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWrBeats = 2'd1,
    StRdBeats = 2'd2,
    StDone    = 2'd3
  } BridgeState;

  // Bridge -> memory bus, one beat at a time.
  typedef struct packed {
    logic                 req;
    logic                 we;
    PkgSnow64Cpu::CpuAddr addr;
    MemBusData            wdata;
  } PartialPortOut_LarFile_MemBus;

  // Memory bus -> bridge.
  typedef struct packed {
    logic      ack;
    MemBusData rdata;
  } PartialPortIn_LarFile_MemBus;

  // Byte address of one beat: line address, beat index, then 8-byte offset.
  function automatic PkgSnow64Cpu::CpuAddr beat_addr(input LarBaseAddr base, input BeatIdx beat);
    return {base, beat, 3'b000};
  endfunction
endpackage

`endif

// File: rtl/snow64_lar_mem_bridge.sv
// Moves one LAR line to/from memory as BEATS bus beats; write-back precedes refill.
// Latency: 6 cycles for a single fill or write-back, 10 for both, plus ack stalls.
// Backpressure: each beat is held on the bus until acked; requests are sampled only when idle.
module snow64_lar_mem_bridge
  import PkgSnow64LarFile::*;
#(
  parameter int LAR_DATA_WIDTH = WIDTH__LAR_DATA,
  parameter int BUS_DATA_WIDTH = WIDTH__MEM_BUS_DATA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_mem_read_req,
  input  LarBaseAddr                in_mem_read_base_addr,
  input  logic                      in_mem_write_req,
  input  logic [LAR_DATA_WIDTH-1:0] in_mem_write_data,
  input  LarBaseAddr                in_mem_write_base_addr,
  output logic                      out_mem_read_valid,
  output logic [LAR_DATA_WIDTH-1:0] out_mem_read_data,
  output logic                      out_mem_write_valid,
  output logic                      out_bus_req,
  output logic                      out_bus_we,
  output PkgSnow64Cpu::CpuAddr      out_bus_addr,
  output logic [BUS_DATA_WIDTH-1:0] out_bus_wdata,
  input  logic                      in_bus_ack,
  input  logic [BUS_DATA_WIDTH-1:0] in_bus_rdata
);

  BridgeState state_q, state_d;
  BeatIdx     beat_q, beat_d;
  logic       have_wr_q, have_wr_d;
  logic       have_rd_q, have_rd_d;
  LarBaseAddr wr_base_q, wr_base_d;
  LarBaseAddr rd_base_q, rd_base_d;
  LarData     wr_line_q, wr_line_d;
  // rd_buf collects beats as they arrive; rd_out is the line shown to the LAR file
  // and only changes when a fill completes.
  LarData     rd_buf_q, rd_buf_d;
  LarData     rd_out_q, rd_out_d;
  logic       rd_vld_q, rd_vld_d;
  logic       wr_vld_q, wr_vld_d;
  LarBaseAddr beat_base;

  PartialPortOut_LarFile_MemBus bus_out_q, bus_out_d;
  PartialPortIn_LarFile_MemBus  bus_in;

  logic beat_ack;
  logic last_beat;

  assign bus_in.ack   = in_bus_ack;
  assign bus_in.rdata = in_bus_rdata;

  // An ack only counts while a beat is actually on the bus.
  assign beat_ack  = bus_out_q.req & bus_in.ack;
  assign last_beat = (beat_q == BeatIdx'(BEATS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state: write beats first so a dirty line leaves before its refill arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_mem_write_req)     state_d = StWrBeats;
        else if (in_mem_read_req) state_d = StRdBeats;
      end
      StWrBeats: begin
        if (beat_ack && last_beat) state_d = have_rd_q ? StRdBeats : StDone;
      end
      StRdBeats: begin
        if (beat_ack && last_beat) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Transaction context: capture in idle, advance the beat and gather read data on acks.
  always_comb begin
    beat_d    = beat_q;
    have_wr_d = have_wr_q;
    have_rd_d = have_rd_q;
    wr_base_d = wr_base_q;
    rd_base_d = rd_base_q;
    wr_line_d = wr_line_q;
    rd_buf_d  = rd_buf_q;
    if (state_q == StIdle) begin
      if (in_mem_write_req || in_mem_read_req) begin
        have_wr_d = in_mem_write_req;
        have_rd_d = in_mem_read_req;
        wr_base_d = in_mem_write_base_addr;
        rd_base_d = in_mem_read_base_addr;
        wr_line_d = in_mem_write_data;
        beat_d    = '0;
      end
    end else if (((state_q == StWrBeats) || (state_q == StRdBeats)) && beat_ack) begin
      // The counter wraps to 0 after the last write beat, ready for the read beats.
      beat_d = beat_q + BeatIdx'(1);
      if (state_q == StRdBeats) begin
        rd_buf_d[int'(beat_q)*WIDTH__MEM_BUS_DATA +: WIDTH__MEM_BUS_DATA] = bus_in.rdata;
      end
    end
  end

  // Output next values, derived from next state so every output leaves a flop.
  always_comb begin
    beat_base       = (state_d == StWrBeats) ? wr_base_d : rd_base_d;
    bus_out_d.req   = (state_d == StWrBeats) || (state_d == StRdBeats);
    bus_out_d.we    = (state_d == StWrBeats);
    bus_out_d.addr  = beat_addr(beat_base, beat_d);
    bus_out_d.wdata = wr_line_d[int'(beat_d)*WIDTH__MEM_BUS_DATA +: WIDTH__MEM_BUS_DATA];
    wr_vld_d        = (state_d == StDone) && have_wr_q;
    rd_vld_d        = (state_d == StDone) && have_rd_q;
    rd_out_d        = rd_vld_d ? rd_buf_d : rd_out_q;
  end

  // Context and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      have_wr_q <= 1'b0;
      have_rd_q <= 1'b0;
      wr_base_q <= '0;
      rd_base_q <= '0;
      wr_line_q <= '0;
      rd_buf_q  <= '0;
      rd_out_q  <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      bus_out_q <= '0;
    end else begin
      beat_q    <= beat_d;
      have_wr_q <= have_wr_d;
      have_rd_q <= have_rd_d;
      wr_base_q <= wr_base_d;
      rd_base_q <= rd_base_d;
      wr_line_q <= wr_line_d;
      rd_buf_q  <= rd_buf_d;
      rd_out_q  <= rd_out_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign out_mem_read_valid  = rd_vld_q;
  assign out_mem_write_valid = wr_vld_q;
  assign out_mem_read_data   = rd_out_q;
  assign out_bus_req         = bus_out_q.req;
  assign out_bus_we          = bus_out_q.we;
  assign out_bus_addr        = bus_out_q.addr;
  assign out_bus_wdata       = bus_out_q.wdata;

endmodule

// File: doc/snow64_lar_mem_bridge.md
SNOW64_LAR_MEM_BRIDGE -- requirements
Module: snow64_lar_mem_bridge

Interface
REQ-001 SHALL have parameters: LAR_DATA_WIDTH, default 256, LAR line width in bits; BUS_DATA_WIDTH, default 64, memory bus beat width in bits; BEATS = LAR_DATA_WIDTH/BUS_DATA_WIDTH, default 4, derived and not overridable.
REQ-002 SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_mem_read_req  in  1  LAR file requests a line fill.
- in_mem_read_base_addr  in  LarBaseAddr (59)  line address to fill.
- in_mem_write_req  in  1  LAR file requests a write-back.
- in_mem_write_data  in  LAR_DATA_WIDTH  line to write back.
- in_mem_write_base_addr  in  LarBaseAddr (59)  line address to write back.
- out_mem_read_valid  out  1  fill complete; one-cycle pulse.
- out_mem_read_data  out  LAR_DATA_WIDTH  filled line.
- out_mem_write_valid  out  1  write-back complete; one-cycle pulse.
- out_bus_req  out  1  bus beat request.
- out_bus_we  out  1  1 = write beat, 0 = read beat.
- out_bus_addr  out  CpuAddr (64)  byte address of the beat.
- out_bus_wdata  out  BUS_DATA_WIDTH  write beat data.
- in_bus_ack  in  1  current beat accepted or completed.
- in_bus_rdata  in  BUS_DATA_WIDTH  read data; valid in the cycle in_bus_ack is high.

Function
REQ-003 SHALL implement states StIdle, StWrBeats, StRdBeats and StDone, encoded as BridgeState.
REQ-004 In StIdle, SHALL sample both request inputs each cycle.
- If either request is high, SHALL latch the high request flag(s), both addresses and the write data, clear the beat counter, and leave StIdle.
- SHALL go to StWrBeats if the write request is high, otherwise to StRdBeats.
REQ-005 When both requests are sampled high in the same cycle, SHALL perform the write-back beats before the read beats, so a dirty line is evicted before it is refilled.
REQ-006 While in StWrBeats or StRdBeats, SHALL hold out_bus_req = 1 and keep out_bus_addr, out_bus_we and out_bus_wdata stable until in_bus_ack is sampled high.
REQ-007 SHALL form the beat address as out_bus_addr = {base_addr, beat[1:0], 3'b000}.
REQ-008 SHALL drive write beat data as out_bus_wdata = write_data[beat*64 +: 64], so beat 0 carries the least-significant 64 bits.
REQ-009 On an ack during a read beat, SHALL store in_bus_rdata into read_data[beat*64 +: 64].
REQ-010 On each ack, SHALL increment the 2-bit beat counter. On the ack of beat BEATS-1, SHALL:
- from StWrBeats, go to StRdBeats if a read request is latched (counter wraps to 0), otherwise to StDone;
- from StRdBeats, go to StDone.
REQ-011 SHALL ignore in_bus_ack whenever out_bus_req is low, and SHALL complete at most one beat per cycle.
REQ-012 In StDone, SHALL:
- assert out_mem_write_valid if a write was latched and out_mem_read_valid if a read was latched (both in the same cycle when both were latched);
- hold out_mem_read_data valid in that cycle;
- drive out_bus_req = 0;
- go to StIdle on the next cycle.
REQ-013 SHALL drive all valid outputs and out_bus_req from registers; no input-to-output combinational path is permitted.
REQ-014 Requests SHALL be sampled only in StIdle; request changes during a transaction are ignored. The requester deasserts req the cycle after the valid pulse.
REQ-015 Minimum latency with a single-cycle ack is:
- read only or write only: 1 capture cycle + 4 beats + 1 done cycle = 6 cycles;
- both: 10 cycles.
REQ-016 out_mem_read_data SHALL keep its last value outside StDone and SHALL NOT be cleared between transactions.

Reset
REQ-017 While rst_n is low, SHALL immediately force the state to StIdle and set the beat counter, latched flags, out_bus_req, out_bus_we, out_mem_read_valid and out_mem_write_valid to 0.
REQ-018 While rst_n is low, SHALL set out_bus_addr, out_bus_wdata and out_mem_read_data to 0.
REQ-019 A reset asserted mid-transaction SHALL abandon the transaction, discard partial read data and produce no valid pulse. Any write beats already acknowledged remain in memory.

Structure
REQ-020 SHALL place in PkgSnow64LarFile:
- the BridgeState enum;
- the BEATS constant and a matching MSB-position define;
- PartialPortOut_LarFile_MemBus and PartialPortIn_LarFile_MemBus structs grouping the bus signals.
REQ-021 SHALL reuse LarData, LarBaseAddr and PkgSnow64Cpu::CpuAddr; widths SHALL NOT be redefined locally.
REQ-022 SHALL be a single module with no sub-modules. The beat slicing is simple indexed part-selects.

Verification
REQ-023 Read only: base_addr 0x1, ack every cycle, rdata beat k = 0x1111_1111_1111_1111*(k+1).
- Bus addresses SHALL be 0x20, 0x28, 0x30, 0x38.
- out_mem_read_valid SHALL pulse in cycle 6 with data {0x4444..., 0x3333..., 0x2222..., 0x1111...}.
REQ-024 Write only: data = 256'h0123_..._CDEF, base 0x2.
- SHALL produce four write beats to 0x40 through 0x58, carrying the low 64 bits first.
- out_mem_write_valid SHALL pulse once; out_mem_read_valid SHALL stay 0.
REQ-025 Both requests in one cycle: SHALL produce four write beats, then four read beats, then both valids pulsing in the same cycle; total 10 cycles.
REQ-026 Ack stalled 3 cycles on beat 2: bus address, we and wdata SHALL stay stable during the stall, the beat SHALL complete once, and the done pulse SHALL move 3 cycles later.
REQ-027 rst_n pulsed low after the second read beat: outputs SHALL be 0 immediately, no valid pulse SHALL follow, and a new read request SHALL then complete normally.
REQ-028 Stray ack in StIdle: SHALL cause no state change and no counter change.
